// File: rtl/pipe_control.sv
// Pipeline control for a 5-stage RV32I core: carries decoded control through
// ID/EX, EX/MEM and MEM/WB, resolves stalls, flushes and bypass selects.
module pipe_control #(
  parameter int CTRL_W     = 16,
  parameter int REG_AW     = 5,
  parameter int FORWARDING = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_id_mem_write,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic              i_ex_redirect,
  input  logic              i_dmem_ready,
  output logic              o_stall_if,
  output logic              o_flush_if,
  output logic              o_ex_valid,
  output logic [REG_AW-1:0] o_ex_rd,
  output logic              o_ex_reg_write,
  output logic              o_ex_mem_read,
  output logic              o_ex_mem_write,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic              o_mem_valid,
  output logic [REG_AW-1:0] o_mem_rd,
  output logic              o_mem_reg_write,
  output logic              o_mem_mem_read,
  output logic              o_mem_mem_write,
  output logic [CTRL_W-1:0] o_mem_ctrl,
  output logic              o_wb_valid,
  output logic [REG_AW-1:0] o_wb_rd,
  output logic              o_wb_reg_write,
  output logic [CTRL_W-1:0] o_wb_ctrl,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic [31:0]       o_stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [CTRL_W-1:0] ctrl;
  } exmem_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic [CTRL_W-1:0] ctrl;
  } memwb_t;

  idex_t       ex_q, ex_d, id_pkt;
  exmem_t      mem_q, mem_d;
  memwb_t      wb_q, wb_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic       mem_stall, redirect, data_hazard, hazard_raw;
  logic       ex_hit, mem_hit, wb_hit;
  logic [1:0] fwd_a, fwd_b;

  // x0 is hard-wired zero, so a producer writing it is never a real dependency.
  function automatic logic prod_match(input logic v, input logic rw,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] src,
                                      input logic use_src);
    return v && rw && (rd != '0) && (rd == src) && use_src;
  endfunction

  assign ex_hit  = prod_match(ex_q.valid, ex_q.reg_write, ex_q.rd, i_id_rs1, i_id_use_rs1)
                || prod_match(ex_q.valid, ex_q.reg_write, ex_q.rd, i_id_rs2, i_id_use_rs2);
  assign mem_hit = prod_match(mem_q.valid, mem_q.reg_write, mem_q.rd, i_id_rs1, i_id_use_rs1)
                || prod_match(mem_q.valid, mem_q.reg_write, mem_q.rd, i_id_rs2, i_id_use_rs2);
  assign wb_hit  = prod_match(wb_q.valid, wb_q.reg_write, wb_q.rd, i_id_rs1, i_id_use_rs1)
                || prod_match(wb_q.valid, wb_q.reg_write, wb_q.rd, i_id_rs2, i_id_use_rs2);

  generate
    if (FORWARDING != 0) begin : g_fwd
      // With bypass only a load in EX is too late to forward.
      assign hazard_raw = ex_hit && ex_q.mem_read;
      always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (prod_match(mem_q.valid, mem_q.reg_write, mem_q.rd, ex_q.rs1, ex_q.use_rs1))
          fwd_a = 2'b01;
        else if (prod_match(wb_q.valid, wb_q.reg_write, wb_q.rd, ex_q.rs1, ex_q.use_rs1))
          fwd_a = 2'b10;
        if (prod_match(mem_q.valid, mem_q.reg_write, mem_q.rd, ex_q.rs2, ex_q.use_rs2))
          fwd_b = 2'b01;
        else if (prod_match(wb_q.valid, wb_q.reg_write, wb_q.rd, ex_q.rs2, ex_q.use_rs2))
          fwd_b = 2'b10;
      end
    end else begin : g_nofwd
      assign hazard_raw = ex_hit || mem_hit || wb_hit;
      assign fwd_a      = 2'b00;
      assign fwd_b      = 2'b00;
    end
  endgenerate

  assign mem_stall   = mem_q.valid && (mem_q.mem_read || mem_q.mem_write) && !i_dmem_ready;
  assign redirect    = !mem_stall && ex_q.valid && i_ex_redirect;
  assign data_hazard = !mem_stall && !redirect && i_id_valid && hazard_raw;

  always_comb begin
    id_pkt = '0;
    if (i_id_valid) begin
      id_pkt.valid     = 1'b1;
      id_pkt.rd        = i_id_rd;
      id_pkt.reg_write = i_id_reg_write;
      id_pkt.mem_read  = i_id_mem_read;
      id_pkt.mem_write = i_id_mem_write;
      id_pkt.ctrl      = i_id_ctrl;
      id_pkt.rs1       = i_id_rs1;
      id_pkt.rs2       = i_id_rs2;
      id_pkt.use_rs1   = i_id_use_rs1;
      id_pkt.use_rs2   = i_id_use_rs2;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (mem_stall) begin
      wb_d = '0;
    end else begin
      mem_d.valid     = ex_q.valid;
      mem_d.rd        = ex_q.rd;
      mem_d.reg_write = ex_q.reg_write;
      mem_d.mem_read  = ex_q.mem_read;
      mem_d.mem_write = ex_q.mem_write;
      mem_d.ctrl      = ex_q.ctrl;
      wb_d.valid      = mem_q.valid;
      wb_d.rd         = mem_q.rd;
      wb_d.reg_write  = mem_q.reg_write;
      wb_d.ctrl       = mem_q.ctrl;
      ex_d            = (redirect || data_hazard) ? idex_t'('0) : id_pkt;
    end
  end

  assign o_stall_if  = mem_stall || data_hazard;
  assign o_flush_if  = redirect;
  assign stall_cnt_d = (o_stall_if && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                      : stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_ex_valid      = ex_q.valid;
  assign o_ex_rd         = ex_q.rd;
  assign o_ex_reg_write  = ex_q.reg_write;
  assign o_ex_mem_read   = ex_q.mem_read;
  assign o_ex_mem_write  = ex_q.mem_write;
  assign o_ex_ctrl       = ex_q.ctrl;
  assign o_mem_valid     = mem_q.valid;
  assign o_mem_rd        = mem_q.rd;
  assign o_mem_reg_write = mem_q.reg_write;
  assign o_mem_mem_read  = mem_q.mem_read;
  assign o_mem_mem_write = mem_q.mem_write;
  assign o_mem_ctrl      = mem_q.ctrl;
  assign o_wb_valid      = wb_q.valid;
  assign o_wb_rd         = wb_q.rd;
  assign o_wb_reg_write  = wb_q.reg_write;
  assign o_wb_ctrl       = wb_q.ctrl;
  assign o_fwd_a         = fwd_a;
  assign o_fwd_b         = fwd_b;
  assign o_stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: one bypass-enabled and one stall-only
// instance share the ID-side stimulus; each test checks the relevant one.
module tb_pipe_control;
  localparam int CW = 16;
  localparam int AW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          id_valid = 1'b0, id_use1 = 1'b0, id_use2 = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_rw = 1'b0, id_mr = 1'b0, id_mw = 1'b0;
  logic [CW-1:0] id_ctrl = '0;
  logic          ex_redirect = 1'b0, dmem_ready = 1'b1;

  logic          a_stall_if, a_flush_if, a_ex_valid, a_ex_rw, a_ex_mr, a_ex_mw;
  logic          a_mem_valid, a_mem_rw, a_mem_mr, a_mem_mw, a_wb_valid, a_wb_rw;
  logic [AW-1:0] a_ex_rd, a_mem_rd, a_wb_rd;
  logic [CW-1:0] a_ex_ctrl, a_mem_ctrl, a_wb_ctrl;
  logic [1:0]    a_fwd_a, a_fwd_b;
  logic [31:0]   a_stall_cnt;

  logic          b_stall_if, b_flush_if, b_ex_valid, b_ex_rw, b_ex_mr, b_ex_mw;
  logic          b_mem_valid, b_mem_rw, b_mem_mr, b_mem_mw, b_wb_valid, b_wb_rw;
  logic [AW-1:0] b_ex_rd, b_mem_rd, b_wb_rd;
  logic [CW-1:0] b_ex_ctrl, b_mem_ctrl, b_wb_ctrl;
  logic [1:0]    b_fwd_a, b_fwd_b;
  logic [31:0]   b_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pipe_control #(.CTRL_W(CW), .REG_AW(AW), .FORWARDING(1)) u_fwd (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use1), .i_id_use_rs2(id_use2),
    .i_id_rd(id_rd), .i_id_reg_write(id_rw), .i_id_mem_read(id_mr), .i_id_mem_write(id_mw),
    .i_id_ctrl(id_ctrl), .i_ex_redirect(ex_redirect), .i_dmem_ready(dmem_ready),
    .o_stall_if(a_stall_if), .o_flush_if(a_flush_if),
    .o_ex_valid(a_ex_valid), .o_ex_rd(a_ex_rd), .o_ex_reg_write(a_ex_rw),
    .o_ex_mem_read(a_ex_mr), .o_ex_mem_write(a_ex_mw), .o_ex_ctrl(a_ex_ctrl),
    .o_mem_valid(a_mem_valid), .o_mem_rd(a_mem_rd), .o_mem_reg_write(a_mem_rw),
    .o_mem_mem_read(a_mem_mr), .o_mem_mem_write(a_mem_mw), .o_mem_ctrl(a_mem_ctrl),
    .o_wb_valid(a_wb_valid), .o_wb_rd(a_wb_rd), .o_wb_reg_write(a_wb_rw), .o_wb_ctrl(a_wb_ctrl),
    .o_fwd_a(a_fwd_a), .o_fwd_b(a_fwd_b), .o_stall_cnt(a_stall_cnt)
  );

  pipe_control #(.CTRL_W(CW), .REG_AW(AW), .FORWARDING(0)) u_nofwd (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use1), .i_id_use_rs2(id_use2),
    .i_id_rd(id_rd), .i_id_reg_write(id_rw), .i_id_mem_read(id_mr), .i_id_mem_write(id_mw),
    .i_id_ctrl(id_ctrl), .i_ex_redirect(ex_redirect), .i_dmem_ready(dmem_ready),
    .o_stall_if(b_stall_if), .o_flush_if(b_flush_if),
    .o_ex_valid(b_ex_valid), .o_ex_rd(b_ex_rd), .o_ex_reg_write(b_ex_rw),
    .o_ex_mem_read(b_ex_mr), .o_ex_mem_write(b_ex_mw), .o_ex_ctrl(b_ex_ctrl),
    .o_mem_valid(b_mem_valid), .o_mem_rd(b_mem_rd), .o_mem_reg_write(b_mem_rw),
    .o_mem_mem_read(b_mem_mr), .o_mem_mem_write(b_mem_mw), .o_mem_ctrl(b_mem_ctrl),
    .o_wb_valid(b_wb_valid), .o_wb_rd(b_wb_rd), .o_wb_reg_write(b_wb_rw), .o_wb_ctrl(b_wb_ctrl),
    .o_fwd_a(b_fwd_a), .o_fwd_b(b_fwd_b), .o_stall_cnt(b_stall_cnt)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2, input logic [AW-1:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic [CW-1:0] c);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use1 = u1; id_use2 = u2;
    id_rd = rd; id_rw = rw; id_mr = mr; id_mw = mw; id_ctrl = c;
  endtask

  task automatic id_idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    id_idle();
    ex_redirect = 1'b0;
    dmem_ready  = 1'b1;
    repeat (2) tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (a_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0b expected 0", a_ex_valid); end
    checks++; if (a_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %0b expected 0", a_mem_valid); end
    checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %0b expected 0", a_wb_valid); end
    checks++; if (a_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", a_stall_cnt); end
    checks++; if ({a_stall_if, a_flush_if, a_fwd_a, a_fwd_b} !== 6'b0) begin errors++; $display("FAIL reset_comb: got %b expected 000000", {a_stall_if, a_flush_if, a_fwd_a, a_fwd_b}); end
    checks++; if (b_ex_rd !== 5'd0 || b_ex_ctrl !== 16'h0) begin errors++; $display("FAIL reset_ex_fields: got rd=%0d ctrl=%h expected 0", b_ex_rd, b_ex_ctrl); end
    do_reset();
    $display("test_reset: done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 16'h0001);
    #1;
    checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL b2b_prod_stall: got %0b expected 0", a_stall_if); end
    tick();
    checks++; if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd5) begin errors++; $display("FAIL b2b_ex_capture: got v=%0b rd=%0d expected v=1 rd=5", a_ex_valid, a_ex_rd); end
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 16'h0002);
    #1;
    checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL b2b_cons_stall: got %0b expected 0", a_stall_if); end
    tick();
    id_idle();
    checks++; if (a_fwd_a !== 2'b01 || a_fwd_b !== 2'b01) begin errors++; $display("FAIL b2b_fwd: got a=%b b=%b expected 01/01", a_fwd_a, a_fwd_b); end
    checks++; if (a_ex_rd !== 5'd6 || a_mem_rd !== 5'd5) begin errors++; $display("FAIL b2b_stage_rd: got ex=%0d mem=%0d expected 6/5", a_ex_rd, a_mem_rd); end
    tick();
    checks++; if (a_wb_valid !== 1'b1 || a_wb_rd !== 5'd5 || a_wb_ctrl !== 16'h0001) begin errors++; $display("FAIL b2b_wb: got v=%0b rd=%0d ctrl=%h expected 1/5/0001", a_wb_valid, a_wb_rd, a_wb_ctrl); end
    checks++; if (a_stall_cnt !== 32'd0) begin errors++; $display("FAIL b2b_cnt: got %0d expected 0", a_stall_cnt); end
    $display("test_back_to_back: done");
  endtask

  task automatic test_load_use_fwd();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 16'h0010);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 16'h0020);
    #1;
    checks++; if (a_stall_if !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b expected 1", a_stall_if); end
    tick();
    checks++; if (a_ex_valid !== 1'b0 || a_ex_ctrl !== 16'h0) begin errors++; $display("FAIL lu_bubble: got v=%0b ctrl=%h expected 0/0000", a_ex_valid, a_ex_ctrl); end
    checks++; if (a_mem_mr !== 1'b1 || a_stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_mem_cnt: got mr=%0b cnt=%0d expected 1/1", a_mem_mr, a_stall_cnt); end
    #1;
    checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL lu_release: got %0b expected 0", a_stall_if); end
    tick();
    id_idle();
    checks++; if (a_ex_rd !== 5'd6 || a_fwd_a !== 2'b10 || a_fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd: got rd=%0d a=%b b=%b expected 6/10/00", a_ex_rd, a_fwd_a, a_fwd_b); end
    checks++; if (a_stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt_final: got %0d expected 1", a_stall_cnt); end
    $display("test_load_use_fwd: done");
  endtask

  task automatic test_load_use_nofwd();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 16'h0010);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 16'h0020);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (b_stall_if !== 1'b1 || b_fwd_a !== 2'b00) begin errors++; $display("FAIL nf_stall%0d: got stall=%0b fwd=%b expected 1/00", i, b_stall_if, b_fwd_a); end
      tick();
    end
    #1;
    checks++; if (b_stall_if !== 1'b0 || b_stall_cnt !== 32'd3) begin errors++; $display("FAIL nf_release: got stall=%0b cnt=%0d expected 0/3", b_stall_if, b_stall_cnt); end
    tick();
    id_idle();
    checks++; if (b_ex_valid !== 1'b1 || b_ex_rd !== 5'd6 || b_fwd_a !== 2'b00) begin errors++; $display("FAIL nf_consumer: got v=%0b rd=%0d fwd=%b expected 1/6/00", b_ex_valid, b_ex_rd, b_fwd_a); end
    $display("test_load_use_nofwd: done");
  endtask

  task automatic test_redirect();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 16'h0010);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 16'h0020);
    ex_redirect = 1'b1;
    #1;
    checks++; if (a_flush_if !== 1'b1 || a_stall_if !== 1'b0) begin errors++; $display("FAIL rd_comb: got flush=%0b stall=%0b expected 1/0", a_flush_if, a_stall_if); end
    tick();
    ex_redirect = 1'b0;
    id_idle();
    checks++; if (a_ex_valid !== 1'b0 || a_ex_rd !== 5'd0) begin errors++; $display("FAIL rd_bubble: got v=%0b rd=%0d expected 0/0", a_ex_valid, a_ex_rd); end
    checks++; if (a_mem_valid !== 1'b1 || a_mem_rd !== 5'd5 || a_stall_cnt !== 32'd0) begin errors++; $display("FAIL rd_advance: got v=%0b rd=%0d cnt=%0d expected 1/5/0", a_mem_valid, a_mem_rd, a_stall_cnt); end
    $display("test_redirect: done");
  endtask

  task automatic test_mem_stall();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 16'h0100);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 16'h0200);
    tick();
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 16'h0400);
    dmem_ready  = 1'b0;
    ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (a_stall_if !== 1'b1 || a_flush_if !== 1'b0) begin errors++; $display("FAIL ms_comb%0d: got stall=%0b flush=%0b expected 1/0", i, a_stall_if, a_flush_if); end
      tick();
      checks++; if (a_mem_mw !== 1'b1 || a_mem_ctrl !== 16'h0100 || a_ex_rd !== 5'd7 || a_wb_valid !== 1'b0) begin errors++; $display("FAIL ms_hold%0d: got mw=%0b ctrl=%h exrd=%0d wbv=%0b expected 1/0100/7/0", i, a_mem_mw, a_mem_ctrl, a_ex_rd, a_wb_valid); end
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (a_flush_if !== 1'b1 || a_stall_if !== 1'b0 || a_stall_cnt !== 32'd4) begin errors++; $display("FAIL ms_ready: got flush=%0b stall=%0b cnt=%0d expected 1/0/4", a_flush_if, a_stall_if, a_stall_cnt); end
    tick();
    ex_redirect = 1'b0;
    id_idle();
    checks++; if (a_mem_rd !== 5'd7 || a_wb_valid !== 1'b1 || a_wb_ctrl !== 16'h0100 || a_ex_valid !== 1'b0) begin errors++; $display("FAIL ms_after: got memrd=%0d wbv=%0b wbctrl=%h exv=%0b expected 7/1/0100/0", a_mem_rd, a_wb_valid, a_wb_ctrl, a_ex_valid); end
    $display("test_mem_stall: done");
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 16'h0100);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 16'h0200);
    tick();
    dmem_ready = 1'b0;
    repeat (2) tick();
    checks++; if (a_stall_cnt !== 32'd2) begin errors++; $display("FAIL rm_precnt: got %0d expected 2", a_stall_cnt); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if ({a_ex_valid, a_mem_valid, a_wb_valid} !== 3'b000) begin errors++; $display("FAIL rm_valids: got %b expected 000", {a_ex_valid, a_mem_valid, a_wb_valid}); end
    checks++; if (a_stall_cnt !== 32'd0 || a_stall_if !== 1'b0) begin errors++; $display("FAIL rm_cnt: got cnt=%0d stall=%0b expected 0/0", a_stall_cnt, a_stall_if); end
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 16'h0800);
    tick();
    i_rst_n = 1'b1;
    #1;
    checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL rm_post_stall: got %0b expected 0", a_stall_if); end
    tick();
    id_idle();
    dmem_ready = 1'b1;
    checks++; if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd9 || a_ex_ctrl !== 16'h0800) begin errors++; $display("FAIL rm_advance: got v=%0b rd=%0d ctrl=%h expected 1/9/0800", a_ex_valid, a_ex_rd, a_ex_ctrl); end
    $display("test_reset_mid_stall: done");
  endtask

  task automatic test_x0();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 16'h0010);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 16'h0020);
    #1;
    checks++; if (a_stall_if !== 1'b0 || b_stall_if !== 1'b0) begin errors++; $display("FAIL x0_stall: got fwd=%0b nofwd=%0b expected 0/0", a_stall_if, b_stall_if); end
    tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 16'h0010);
    checks++; if (a_fwd_a !== 2'b00 || a_fwd_b !== 2'b00) begin errors++; $display("FAIL x0_fwd: got a=%b b=%b expected 00/00", a_fwd_a, a_fwd_b); end
    tick();
    set_id(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 16'h0020);
    #1;
    checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL x0_unused_src: got %0b expected 0", a_stall_if); end
    tick();
    id_idle();
    $display("test_x0: done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use_fwd();
    test_load_use_nofwd();
    test_redirect();
    test_mem_stall();
    test_reset_mid_stall();
    test_x0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined successor to the single-cycle control decoder: carries decoded control bits through ID/EX, EX/MEM and MEM/WB, detects data hazards, generates stall, flush and forwarding selects, and counts stall cycles. Sits between the decoder/control output in ID and the datapath pipeline registers of the 5-stage RV32I core. The control bundle width and the hazard policy are parameters: full bypass, or stall-only for bring-up.

## Interface
- CTRL_W, 16, width of the opaque control bundle carried alongside each instruction (alu_op, branch_op, masks, etc.)
- REG_AW, 5, register address width
- FORWARDING, 1, 1 = bypass network enabled; 0 = no bypass, stall until producer retires

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs1, i_id_rs2  in  REG_AW  source registers of ID instruction
- i_id_use_rs1, i_id_use_rs2  in  1  source actually read
- i_id_rd  in  REG_AW  destination register
- i_id_reg_write, i_id_mem_read, i_id_mem_write  in  1  decoded control
- i_id_ctrl  in  CTRL_W  remaining control bundle
- i_ex_redirect  in  1  EX resolved a taken branch/jump
- i_dmem_ready  in  1  data memory can complete access this cycle
- o_stall_if  out  1  hold PC and IF/ID register
- o_flush_if  out  1  squash IF/ID register
- o_ex_valid, o_ex_rd, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_ctrl  out  1/REG_AW/1/1/1/CTRL_W  ID/EX register contents
- o_mem_valid, o_mem_rd, o_mem_reg_write, o_mem_mem_read, o_mem_mem_write, o_mem_ctrl  out  same widths  EX/MEM register contents
- o_wb_valid, o_wb_rd, o_wb_reg_write, o_wb_ctrl  out  1/REG_AW/1/CTRL_W  MEM/WB register contents
- o_fwd_a, o_fwd_b  out  2  EX operand source: 00 regfile, 01 MEM-stage result, 10 WB-stage result
- o_stall_cnt  out  32  stall-cycle performance counter

## Operation
- Three pipeline control registers, each with a valid bit; a bubble is valid=0 with all control fields zero. ID/EX also stores rs1/rs2 and use flags for forwarding.
- Producer match (stage S, source r): S valid, S reg_write, S rd != 0, rd == r, use flag set.
- Memory stall (mem_stall): MEM valid, (mem_read or mem_write), i_dmem_ready=0. ID/EX, EX/MEM and IF/ID hold; MEM/WB loads a bubble; o_stall_if=1. Highest priority; masks redirect and data hazard.
- Redirect (not mem_stall, EX valid, i_ex_redirect): EX advances normally; ID/EX loads a bubble (ID instruction is wrong-path); o_flush_if=1, o_stall_if=0. Overrides data-hazard stall.
- Data hazard (not mem_stall, no redirect, i_id_valid):
  - FORWARDING=1: EX producer match with o_ex_mem_read=1 (load-use).
  - FORWARDING=0: producer match in EX, MEM or WB.
  - Action: o_stall_if=1, ID/EX loads bubble, EX/MEM and MEM/WB advance.
- Otherwise all registers advance; ID/EX captures ID inputs with valid=i_id_valid.
- Forwarding (FORWARDING=1, combinational from stored EX sources): MEM match -> 01, else WB match -> 10, else 00; MEM wins over WB. FORWARDING=0: always 00.
- o_stall_cnt increments each cycle o_stall_if=1; saturates at 0xFFFF_FFFF.

## Timing
- Reset (i_rst_n low, asynchronous): all valid bits, rd, control fields and o_stall_cnt to 0; o_stall_if, o_flush_if, o_fwd_* evaluate to 0. Reset mid-stall discards all in-flight state; first cycle after release is a normal advance.
- All registers update on rising i_clk; o_stall_if, o_flush_if, o_fwd_* are combinational from current register state and ID inputs in the same cycle.
- Latency ID->EX->MEM->WB: one cycle per stage absent stalls.
- Load-use with FORWARDING=1 costs exactly 1 stall cycle; consumer then sees o_fwd=10.
- rd=0 never matches; x0 producers never stall or forward.
- Stall counter updates on the edge ending the stalled cycle.

## Test plan
- Back-to-back add x5 then add x6,x5,x5 (FORWARDING=1) -> no stall, o_fwd_a=o_fwd_b=01 in consumer's EX cycle; o_stall_cnt stays 0.
- lw x5 then add x6,x5,x0 -> o_stall_if=1 one cycle, bubble in EX, then o_fwd_a=10; o_stall_cnt=1.
- Same pair with FORWARDING=0 -> o_stall_if=1 for 3 cycles (EX, MEM, WB matches); o_fwd always 00; o_stall_cnt=3.
- i_ex_redirect=1 while ID holds a load-use consumer -> o_flush_if=1, o_stall_if=0, ID/EX bubble next cycle.
- sw in MEM with i_dmem_ready=0 for 4 cycles plus simultaneous i_ex_redirect -> EX/MEM held 4 cycles, 4 WB bubbles, redirect ignored until ready; o_stall_cnt=4.
- Assert i_rst_n low mid-memory-stall -> all valids 0 immediately (no clock), o_stall_cnt=0.
